sigmoid_backward: RTL and testbench
===================================

Name: sigmoid_backward

Overview:
- Backward-pass companion to the forward piecewise-linear sigmoid activation.
- Takes the stored forward output y and the upstream gradient g, and returns dx = g * y * (1 - y) for training/backprop.
- Streaming 2-stage pipeline with valid/ready handshakes on both sides. Sits between the gradient buffer and the preceding layer's weight-update path.
- All data is signed fixed point, WIDTH bits, FRAC_BITS fractional bits, matching the forward activation (1.0 = 0x0200 at defaults).

Parameters:
- WIDTH, 16, data width of y_in, g_in, dx_out (signed two's complement).
- FRAC_BITS, 9, fractional bits; ONE = 1 << FRAC_BITS.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- s_valid  input  1  input sample valid.
- s_ready  output  1  block can accept input this cycle.
- y_in  input  WIDTH  forward sigmoid output, signed Q(FRAC_BITS).
- g_in  input  WIDTH  upstream gradient, signed Q(FRAC_BITS).
- m_valid  output  1  dx_out valid.
- m_ready  input  1  downstream accepts dx_out.
- dx_out  output  WIDTH  input gradient, signed Q(FRAC_BITS).
- clamp_flag  output  1  sticky: some accepted y_in was outside [0, ONE].
- sample_cnt  output  16  count of accepted inputs, wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst_n=0 at a clk edge): both stage-valid bits=0, m_valid=0, dx_out=0, clamp_flag=0, sample_cnt=0. Samples in flight are discarded; no partial output ever appears.
- Input accept: s_valid & s_ready at the edge. s_ready = ~v1 | adv1, where adv1 = ~v2 | m_ready. s_ready is combinational from m_ready; no skid buffer.
- Stage 1, on accept:
  - yc = clamp(y_in, 0, ONE) (signed compare).
  - d = (yc * (ONE - yc)) >> FRAC_BITS, unsigned floor. d width FRAC_BITS+1; maximum 0x80 at yc = 0x100.
  - Register d and g_in. v1 = 1.
  - If y_in < 0 or y_in > ONE, set clamp_flag; it stays set until reset.
- Stage 1 idle: if adv1 and no accept, v1 <= 0. If not adv1, stage 1 holds.
- Stage 2: when adv1 and v1, p = signed(g) * d (WIDTH+FRAC_BITS+2 bits), dx = p >>> FRAC_BITS (arithmetic, floor toward -inf). Register dx; v2 = 1.
  - No saturation needed: |dx| <= |g|/4.
- Stage 2 handshake: if m_ready & v2 and stage 1 is not advancing, v2 <= 0. m_valid = v2. dx_out is held stable while m_valid & ~m_ready.
- Latency: accepted at edge N -> m_valid at edge N+2 when unstalled. Throughput 1 sample/cycle.
- sample_cnt increments on every input accept; 16-bit wrap.
- Order preserved; no sample dropped or duplicated under any m_ready pattern.
- Simultaneous accept and output handshake in the same cycle: both occur, pipeline stays full.

Test Plan:
- y=0x0100, g=0x0200, m_ready=1 -> two edges after accept: m_valid=1, dx_out=0x0080. sample_cnt=1.
- y=0x0180, g=0x0200 -> dx_out=0x0060. Then y=0x0180, g=0xFC00 -> dx_out=0xFF40 (-0.375 = -192/512).
- y=0x0300, then y=0xFF00, each with g=0x0200 -> dx_out=0x0000 both times; clamp_flag=1 from the cycle after the first accept. y=0x0200 alone leaves clamp_flag=0.
- Backpressure: hold m_ready=0 and offer 4 back-to-back samples -> exactly 2 accepted, then s_ready=0. Release m_ready -> outputs in original order, 1 per cycle, dx_out stable while stalled, remaining samples accepted.
- Streaming 65537 samples with m_ready=1 -> sample_cnt wraps to 0x0001, no bubbles after the 2-cycle fill.
- rst_n=0 for one edge with both stages full and clamp_flag=1 -> next cycle m_valid=0, dx_out=0, clamp_flag=0, sample_cnt=0, s_ready=1.

Source files
------------

// File: rtl/sigmoid_backward.sv
// Backward pass of the piecewise-linear sigmoid: dx = g * y * (1 - y), two-stage
// valid/ready pipeline with a sticky out-of-range flag and an accepted-sample counter.
module sigmoid_backward #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FRAC_BITS = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] g_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] dx_out,
    output logic             clamp_flag,
    output logic [15:0]      sample_cnt
);

    localparam int unsigned DW = FRAC_BITS + 1;
    localparam int unsigned PW = WIDTH + FRAC_BITS + 2;
    localparam logic [DW-1:0] ONE = {1'b1, {FRAC_BITS{1'b0}}};
    localparam logic signed [WIDTH-1:0] ONE_S = WIDTH'(1 << FRAC_BITS);

    logic             v1_q, v1_d, v2_q, v2_d;
    logic [DW-1:0]    d_q;
    logic [WIDTH-1:0] g_q, dx_q;
    logic             clamp_q;
    logic [15:0]      cnt_q;

    logic             adv1, accept;
    logic             y_neg, y_hi;
    logic [DW-1:0]    yc, one_minus_y, d_next;
    logic [2*DW-1:0]  d_prod;
    logic [PW-1:0]    p;
    logic [WIDTH-1:0] dx_next;
    logic             unused_bits;

    assign adv1    = ~v2_q | m_ready;
    assign s_ready = ~v1_q | adv1;
    assign accept  = s_valid & s_ready;

    // Stage 1: clamp y into [0, ONE] and form the derivative y*(1-y)
    assign y_neg       = y_in[WIDTH-1];
    assign y_hi        = $signed(y_in) > ONE_S;
    assign yc          = y_neg ? '0 : (y_hi ? ONE : y_in[DW-1:0]);
    assign one_minus_y = ONE - yc;
    assign d_prod      = {{DW{1'b0}}, yc} * {{DW{1'b0}}, one_minus_y};
    assign d_next      = d_prod[FRAC_BITS +: DW];

    // Stage 2: sign-extended product; low PW bits match the signed product, and the
    // slice above FRAC_BITS is the floor-toward-minus-infinity shift.
    assign p       = {{(PW-WIDTH){g_q[WIDTH-1]}}, g_q} * {{(PW-DW){1'b0}}, d_q};
    assign dx_next = p[FRAC_BITS +: WIDTH];

    assign unused_bits = ^{d_prod[2*DW-1], d_prod[FRAC_BITS-1:0],
                           p[PW-1:FRAC_BITS+WIDTH], p[FRAC_BITS-1:0]};

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (accept) begin
            v1_d = 1'b1;
        end else if (adv1) begin
            v1_d = 1'b0;
        end
        if (adv1) begin
            v2_d = v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            d_q     <= '0;
            g_q     <= '0;
            dx_q    <= '0;
            clamp_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (accept) begin
                d_q   <= d_next;
                g_q   <= g_in;
                cnt_q <= cnt_q + 16'd1;
                if (y_neg || y_hi) begin
                    clamp_q <= 1'b1;
                end
            end
            if (adv1 && v1_q) begin
                dx_q <= dx_next;
            end
        end
    end

    assign m_valid    = v2_q;
    assign dx_out     = dx_q;
    assign clamp_flag = clamp_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_sigmoid_backward.sv
// Directed-vector bench for sigmoid_backward: values, clamping, backpressure,
// counter wrap and reset with a full pipeline.
module tb_sigmoid_backward;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] y_in;
    logic [15:0] g_in;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] dx_out;
    logic        clamp_flag;
    logic [15:0] sample_cnt;

    int n_vec = 0;
    int n_err = 0;

    sigmoid_backward #(.WIDTH(16), .FRAC_BITS(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .y_in       (y_in),
        .g_in       (g_in),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .dx_out     (dx_out),
        .clamp_flag (clamp_flag),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    // One-cycle offer; callers use it only while the pipeline can accept.
    task automatic drive(input logic [15:0] y, input logic [15:0] g);
        y_in = y; g_in = g; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        m_ready = 1'b1; y_in = '0; g_in = '0;
        apply_reset();
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_vec++; if (dx_out !== 16'h0000) begin n_err++; $display("FAIL reset_dx: got %h want 0000", dx_out); end
        n_vec++; if (clamp_flag !== 1'b0) begin n_err++; $display("FAIL reset_clamp: got %b want 0", clamp_flag); end
        n_vec++; if (sample_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_cnt: got %h want 0000", sample_cnt); end
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        drive(16'h0100, 16'h0200);
        @(posedge clk); #1;
        n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", m_valid); end
        n_vec++; if (dx_out !== 16'h0080) begin n_err++; $display("FAIL basic_dx: got %h want 0080", dx_out); end
        n_vec++; if (sample_cnt !== 16'h0001) begin n_err++; $display("FAIL basic_cnt: got %h want 0001", sample_cnt); end
        @(posedge clk); #1;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", m_valid); end
    endtask

    task automatic test_values();
        m_ready = 1'b1;
        drive(16'h0180, 16'h0200);
        drive(16'h0180, 16'hFC00);
        n_vec++; if (m_valid !== 1'b1 || dx_out !== 16'h0060) begin n_err++; $display("FAIL val_pos: got %b/%h want 1/0060", m_valid, dx_out); end
        drive(16'h0100, 16'hFFFF);
        n_vec++; if (m_valid !== 1'b1 || dx_out !== 16'hFF40) begin n_err++; $display("FAIL val_neg: got %b/%h want 1/ff40", m_valid, dx_out); end
        drive(16'h0100, 16'h0001);
        n_vec++; if (dx_out !== 16'hFFFF) begin n_err++; $display("FAIL val_floor_neg: got %h want ffff", dx_out); end
        @(posedge clk); #1;
        n_vec++; if (m_valid !== 1'b1 || dx_out !== 16'h0000) begin n_err++; $display("FAIL val_floor_pos: got %b/%h want 1/0000", m_valid, dx_out); end
        n_vec++; if (sample_cnt !== 16'h0005) begin n_err++; $display("FAIL val_cnt: got %h want 0005", sample_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_clamp();
        m_ready = 1'b1;
        drive(16'h0200, 16'h0200);
        n_vec++; if (clamp_flag !== 1'b0) begin n_err++; $display("FAIL clamp_one: got %b want 0", clamp_flag); end
        drive(16'h0300, 16'h0200);
        n_vec++; if (clamp_flag !== 1'b1) begin n_err++; $display("FAIL clamp_set: got %b want 1", clamp_flag); end
        n_vec++; if (m_valid !== 1'b1 || dx_out !== 16'h0000) begin n_err++; $display("FAIL clamp_dx_one: got %b/%h want 1/0000", m_valid, dx_out); end
        drive(16'hFF00, 16'h0200);
        n_vec++; if (m_valid !== 1'b1 || dx_out !== 16'h0000) begin n_err++; $display("FAIL clamp_dx_hi: got %b/%h want 1/0000", m_valid, dx_out); end
        @(posedge clk); #1;
        n_vec++; if (m_valid !== 1'b1 || dx_out !== 16'h0000) begin n_err++; $display("FAIL clamp_dx_neg: got %b/%h want 1/0000", m_valid, dx_out); end
        n_vec++; if (clamp_flag !== 1'b1) begin n_err++; $display("FAIL clamp_sticky: got %b want 1", clamp_flag); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [15:0] ys [4];
        logic [15:0] exp_dx [4];
        int in_idx = 0;
        int out_idx = 0;
        logic fire_in, fire_out;
        ys = '{16'h0100, 16'h0180, 16'h0040, 16'h00C0};
        exp_dx = '{16'h0080, 16'h0060, 16'h0038, 16'h0078};
        for (int cyc = 0; cyc < 20 && out_idx < 4; cyc++) begin
            m_ready = (cyc >= 4);
            s_valid = (in_idx < 4);
            y_in = (in_idx < 4) ? ys[in_idx] : 16'h0000;
            g_in = 16'h0200;
            @(negedge clk);
            if (cyc == 3) begin
                n_vec++; if (in_idx != 2 || s_ready !== 1'b0) begin n_err++; $display("FAIL bp_accepts: got %0d/%b want 2/0", in_idx, s_ready); end
            end
            if (cyc == 2 || cyc == 3) begin
                n_vec++; if (m_valid !== 1'b1 || dx_out !== 16'h0080) begin n_err++; $display("FAIL bp_hold: got %b/%h want 1/0080", m_valid, dx_out); end
            end
            if (cyc >= 4 && cyc <= 7) begin
                n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_stream cyc %0d: got %b want 1", cyc, m_valid); end
            end
            fire_in  = s_valid && s_ready;
            fire_out = m_valid && m_ready;
            if (fire_out) begin
                n_vec++; if (dx_out !== exp_dx[out_idx]) begin n_err++; $display("FAIL bp_order %0d: got %h want %h", out_idx, dx_out, exp_dx[out_idx]); end
                out_idx++;
            end
            @(posedge clk); #1;
            if (fire_in) in_idx++;
        end
        s_valid = 1'b0;
        n_vec++; if (out_idx != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", out_idx); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int bubbles = 0;
        m_ready = 1'b1;
        apply_reset();
        y_in = 16'h0100; g_in = 16'h0200; s_valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            @(negedge clk);
            if (i >= 2 && m_valid !== 1'b1) bubbles++;
            if (i == 65536) begin
                n_vec++; if (sample_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_zero: got %h want 0000", sample_cnt); end
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        n_vec++; if (sample_cnt !== 16'h0001) begin n_err++; $display("FAIL wrap_cnt: got %h want 0001", sample_cnt); end
        n_vec++; if (bubbles != 0) begin n_err++; $display("FAIL wrap_bubbles: got %0d want 0", bubbles); end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_full();
        m_ready = 1'b0;
        drive(16'h0100, 16'h0200);
        drive(16'h0300, 16'h0200);
        n_vec++; if (m_valid !== 1'b1 || dx_out !== 16'h0080 || clamp_flag !== 1'b1) begin n_err++; $display("FAIL rf_full: got %b/%h/%b want 1/0080/1", m_valid, dx_out, clamp_flag); end
        apply_reset();
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rf_m_valid: got %b want 0", m_valid); end
        n_vec++; if (dx_out !== 16'h0000) begin n_err++; $display("FAIL rf_dx: got %h want 0000", dx_out); end
        n_vec++; if (clamp_flag !== 1'b0) begin n_err++; $display("FAIL rf_clamp: got %b want 0", clamp_flag); end
        n_vec++; if (sample_cnt !== 16'h0000) begin n_err++; $display("FAIL rf_cnt: got %h want 0000", sample_cnt); end
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rf_s_ready: got %b want 1", s_ready); end
        m_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rf_no_ghost: got %b want 0", m_valid); end
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1; y_in = '0; g_in = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_values();
        test_clamp();
        test_backpressure();
        test_wrap();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
